// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_arbiter
// Description : Round-robin arbiter sharing one classic Wishbone slave among
//               N_MASTER masters, with a stalled-slave watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter #(
    parameter int N_MASTER = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic [N_MASTER-1:0]   m_cyc_i,
    input  logic [N_MASTER-1:0]   m_stb_i,
    input  logic [N_MASTER-1:0]   m_we_i,
    input  logic [32*N_MASTER-1:0] m_adr_i,
    input  logic [32*N_MASTER-1:0] m_dat_i,
    input  logic [4*N_MASTER-1:0] m_sel_i,
    output logic [31:0]           m_dat_o,
    output logic [N_MASTER-1:0]   m_ack_o,
    output logic [N_MASTER-1:0]   m_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [31:0]           s_adr_o,
    output logic [31:0]           s_dat_o,
    output logic [3:0]            s_sel_o,
    input  logic [31:0]           s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    output logic [N_MASTER-1:0]   grant_o
);

    localparam int c_IDX_W = $clog2(N_MASTER);
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_OWNED = 1'b1;

    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(N_MASTER - 1);
    localparam logic [c_CNT_W-1:0] c_TCNT_MAX = c_CNT_W'(TIMEOUT - 1);

    logic [0:0]          r_state;
    logic [N_MASTER-1:0] r_grant;
    logic [c_IDX_W-1:0]  r_last;
    logic [c_CNT_W-1:0]  r_tcnt;

    logic [0:0]          w_state_nxt;
    logic [N_MASTER-1:0] w_grant_nxt;
    logic [c_IDX_W-1:0]  w_last_nxt;
    logic [c_CNT_W-1:0]  w_tcnt_nxt;

    logic                w_owned;
    logic                w_found;
    logic [c_IDX_W-1:0]  w_pick;
    logic                w_cyc_g;
    logic                w_stb_g;
    logic                w_we_g;
    logic [31:0]         w_adr_g;
    logic [31:0]         w_dat_g;
    logic [3:0]          w_sel_g;
    logic                w_stb_raw;
    logic                w_stall;
    logic                w_abort;

    assign w_owned = (r_state == c_ST_OWNED);

    // Round-robin scan: indices above the previous owner first, then wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        for (int i = 0; i < N_MASTER; i++) begin
            if (!w_found && m_cyc_i[i] && (c_IDX_W'(i) > r_last)) begin
                w_found = 1'b1;
                w_pick  = c_IDX_W'(i);
            end
        end
        for (int i = 0; i < N_MASTER; i++) begin
            if (!w_found && m_cyc_i[i] && (c_IDX_W'(i) <= r_last)) begin
                w_found = 1'b1;
                w_pick  = c_IDX_W'(i);
            end
        end
    end

    // While OWNED, r_last always holds the owner's index.
    always_comb begin
        w_cyc_g = 1'b0;
        w_stb_g = 1'b0;
        w_we_g  = 1'b0;
        w_adr_g = '0;
        w_dat_g = '0;
        w_sel_g = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (r_last == c_IDX_W'(i)) begin
                w_cyc_g = m_cyc_i[i];
                w_stb_g = m_stb_i[i];
                w_we_g  = m_we_i[i];
                w_adr_g = m_adr_i[32*i +: 32];
                w_dat_g = m_dat_i[32*i +: 32];
                w_sel_g = m_sel_i[4*i +: 4];
            end
        end
    end

    assign w_stb_raw = w_owned & w_stb_g;
    assign w_stall   = w_stb_raw & ~s_ack_i & ~s_err_i;
    assign w_abort   = w_stall & (r_tcnt == c_TCNT_MAX);

    assign s_cyc_o = w_owned & w_cyc_g;
    assign s_stb_o = w_stb_raw & ~w_abort;
    assign s_we_o  = w_owned & w_we_g;
    assign s_adr_o = w_owned ? w_adr_g : 32'h0;
    assign s_dat_o = w_owned ? w_dat_g : 32'h0;
    assign s_sel_o = w_owned ? w_sel_g : 4'h0;
    assign m_dat_o = s_dat_i;
    assign grant_o = r_grant;

    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_resp
            assign m_ack_o[gi] = r_grant[gi] & w_stb_raw & s_ack_i;
            assign m_err_o[gi] = r_grant[gi] & ((w_stb_raw & s_err_i) | w_abort);
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_tcnt_nxt  = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_ST_OWNED;
                    w_grant_nxt = N_MASTER'(1) << w_pick;
                    w_last_nxt  = w_pick;
                end
            end
            c_ST_OWNED: begin
                if (!w_cyc_g) begin
                    w_state_nxt = c_ST_IDLE;
                    w_grant_nxt = '0;
                end else if (w_stall && !w_abort) begin
                    w_tcnt_nxt = r_tcnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            r_state <= c_ST_IDLE;
            r_grant <= '0;
            r_last  <= c_LAST_RST;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_rr_arbiter
// Description : Self-checking bench for wb_rr_arbiter (table, directed, random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter;

    localparam int N   = 3;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  cyc, stb, we;
    logic [95:0] adr, dat;
    logic [11:0] sel;
    logic [31:0] m_dat;
    logic [2:0]  m_ack, m_err, grant;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dato;
    logic [3:0]  s_sel;
    logic [31:0] s_dati;
    logic        s_ack, s_err;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.N_MASTER(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn_i(rstn),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
        .m_adr_i(adr), .m_dat_i(dat), .m_sel_i(sel),
        .m_dat_o(m_dat), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_dato), .s_sel_o(s_sel),
        .s_dat_i(s_dati), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference: owner index (-1 = idle), previous owner, stalled strobe count.
    int mo_owner = -1;
    int mo_last  = N - 1;
    int mo_cnt   = 0;

    logic [2:0]  e_grant, e_ack, e_err;
    logic        e_scyc, e_sstb, e_swe, e_stall, e_abort;
    logic [31:0] e_sadr, e_sdat, e_mdat;
    logic [3:0]  e_ssel;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic compute_expect();
        int o;
        e_grant = '0; e_ack = '0; e_err = '0;
        e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0; e_stall = 1'b0; e_abort = 1'b0;
        e_sadr = '0; e_sdat = '0; e_ssel = '0;
        e_mdat = s_dati;
        if (mo_owner >= 0) begin
            o = mo_owner;
            e_stall  = stb[o] && !s_ack && !s_err;
            e_abort  = e_stall && (mo_cnt + 1 == TMO);
            e_grant[o] = 1'b1;
            e_scyc   = cyc[o];
            e_sstb   = stb[o] && !e_abort;
            e_swe    = we[o];
            e_sadr   = adr[32*o +: 32];
            e_sdat   = dat[32*o +: 32];
            e_ssel   = sel[4*o +: 4];
            e_ack[o] = s_ack && stb[o];
            e_err[o] = (s_err && stb[o]) || e_abort;
        end
    endtask

    task automatic model_update();
        bit found;
        int c;
        if (!rstn) begin
            mo_owner = -1; mo_last = N - 1; mo_cnt = 0;
        end else if (mo_owner < 0) begin
            mo_cnt = 0;
            found  = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (mo_last + k) % N;
                if (!found && cyc[c]) begin
                    found = 1'b1; mo_owner = c; mo_last = c;
                end
            end
        end else if (!cyc[mo_owner]) begin
            mo_owner = -1; mo_cnt = 0;
        end else if (e_stall && !e_abort) begin
            mo_cnt++;
        end else begin
            mo_cnt = 0;
        end
    endtask

    // One clock: settle, compare against the model, take the edge, advance model.
    task automatic step();
        #1;
        compute_expect();
        if (chk_en) begin
            chk("grant", 32'(grant), 32'(e_grant));
            chk("s_ctl", 32'({s_cyc, s_stb, s_we}), 32'({e_scyc, e_sstb, e_swe}));
            chk("s_adr", s_adr, e_sadr);
            chk("s_dat", s_dato, e_sdat);
            chk("s_sel", 32'(s_sel), 32'(e_ssel));
            chk("m_ack", 32'(m_ack), 32'(e_ack));
            chk("m_err", 32'(m_err), 32'(e_err));
            chk("m_dat", m_dat, e_mdat);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic        rstn;
        logic [2:0]  cyc;
        logic [2:0]  stb;
        logic        ack;
        logic        err;
        logic [31:0] sdat;
        logic [2:0]  g;
        logic        scyc;
        logic        sstb;
        logic [31:0] sadr;
        logic [2:0]  acke;
        logic [2:0]  erre;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    initial begin
        // Fixed masters: m0 writes 0x100, m1 reads 0x40, m2 writes 0x200.
        tbl[0]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 32'h11,       3'b000, 1'b0, 1'b0, 32'h0,   3'b000, 3'b000};
        tbl[1]  = '{1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 32'h22,       3'b000, 1'b0, 1'b0, 32'h0,   3'b000, 3'b000};
        tbl[2]  = '{1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 32'h33,       3'b010, 1'b1, 1'b1, 32'h40,  3'b000, 3'b000};
        tbl[3]  = '{1'b1, 3'b010, 3'b010, 1'b1, 1'b0, 32'hDEADBEEF, 3'b010, 1'b1, 1'b1, 32'h40,  3'b010, 3'b000};
        tbl[4]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 32'h44,       3'b010, 1'b0, 1'b0, 32'h40,  3'b000, 3'b000};
        tbl[5]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 32'h55,       3'b000, 1'b0, 1'b0, 32'h0,   3'b000, 3'b000};
        tbl[6]  = '{1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 32'h66,       3'b000, 1'b0, 1'b0, 32'h0,   3'b000, 3'b000};
        tbl[7]  = '{1'b1, 3'b101, 3'b101, 1'b0, 1'b0, 32'h77,       3'b000, 1'b0, 1'b0, 32'h0,   3'b000, 3'b000};
        tbl[8]  = '{1'b1, 3'b101, 3'b101, 1'b1, 1'b0, 32'h88,       3'b001, 1'b1, 1'b1, 32'h100, 3'b001, 3'b000};
        tbl[9]  = '{1'b1, 3'b100, 3'b100, 1'b0, 1'b0, 32'h99,       3'b001, 1'b0, 1'b0, 32'h100, 3'b000, 3'b000};
        tbl[10] = '{1'b1, 3'b100, 3'b100, 1'b0, 1'b0, 32'hAA,       3'b000, 1'b0, 1'b0, 32'h0,   3'b000, 3'b000};
        tbl[11] = '{1'b1, 3'b100, 3'b100, 1'b0, 1'b0, 32'hBB,       3'b100, 1'b1, 1'b1, 32'h200, 3'b000, 3'b000};
        tbl[12] = '{1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 32'hCC,       3'b100, 1'b1, 1'b1, 32'h200, 3'b000, 3'b000};
        tbl[13] = '{1'b1, 3'b110, 3'b110, 1'b0, 1'b0, 32'hDD,       3'b000, 1'b0, 1'b0, 32'h0,   3'b000, 3'b000};
        tbl[14] = '{1'b1, 3'b110, 3'b000, 1'b1, 1'b1, 32'hEE,       3'b010, 1'b1, 1'b0, 32'h40,  3'b000, 3'b000};
        tbl[15] = '{1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 32'hFF,       3'b010, 1'b0, 1'b0, 32'h40,  3'b000, 3'b000};
        tbl[16] = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 32'h101,      3'b000, 1'b0, 1'b0, 32'h0,   3'b000, 3'b000};
        tbl[17] = '{1'b1, 3'b001, 3'b001, 1'b0, 1'b0, 32'h102,      3'b000, 1'b0, 1'b0, 32'h0,   3'b000, 3'b000};
        tbl[18] = '{1'b1, 3'b001, 3'b001, 1'b0, 1'b1, 32'h103,      3'b001, 1'b1, 1'b1, 32'h100, 3'b000, 3'b001};
        tbl[19] = '{1'b1, 3'b000, 3'b001, 1'b0, 1'b0, 32'h104,      3'b001, 1'b0, 1'b1, 32'h100, 3'b000, 3'b000};
        tbl[20] = '{1'b1, 3'b000, 3'b001, 1'b0, 1'b0, 32'h105,      3'b000, 1'b0, 1'b0, 32'h0,   3'b000, 3'b000};

        rstn = 1'b0; cyc = '0; stb = '0; we = 3'b101;
        adr  = {32'h200, 32'h40, 32'h100};
        dat  = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
        sel  = 12'hF3C;
        s_dati = '0; s_ack = 1'b0; s_err = 1'b0;
        step();
        step();
        chk_en = 1'b1;

        for (int i = 0; i < NV; i++) begin
            rstn = tbl[i].rstn; cyc = tbl[i].cyc; stb = tbl[i].stb;
            s_ack = tbl[i].ack; s_err = tbl[i].err; s_dati = tbl[i].sdat;
            #1;
            chk("t_grant", 32'(grant), 32'(tbl[i].g));
            chk("t_scyc", 32'(s_cyc), 32'(tbl[i].scyc));
            chk("t_sstb", 32'(s_stb), 32'(tbl[i].sstb));
            chk("t_sadr", s_adr, tbl[i].sadr);
            chk("t_ack", 32'(m_ack), 32'(tbl[i].acke));
            chk("t_err", 32'(m_err), 32'(tbl[i].erre));
            chk("t_mdat", m_dat, tbl[i].sdat);
            step();
        end

        // Timeout on a master 0 write, then a retry that must time out afresh.
        rstn = 1'b1; cyc = 3'b001; stb = 3'b001; s_ack = 1'b0; s_err = 1'b0;
        step();
        for (int r = 0; r < 2; r++) begin
            for (int s = 1; s <= TMO; s++) begin
                #1;
                chk("tmo_err", 32'(m_err), (s == TMO) ? 32'h1 : 32'h0);
                chk("tmo_stb", 32'(s_stb), (s == TMO) ? 32'h0 : 32'h1);
                step();
            end
        end
        cyc = '0; stb = '0;
        step();
        step();

        // Fairness: every master always requesting, one-beat cycles.
        rstn = 1'b0;
        step();
        rstn = 1'b1; cyc = 3'b111; stb = 3'b111; s_ack = 1'b1;
        step();
        for (int n = 0; n < 2 * N; n++) begin
            #1;
            chk("fair_grant", 32'(grant), 32'(1) << (n % N));
            chk("fair_ack", 32'(m_ack), 32'(1) << (n % N));
            step();
            cyc = 3'b111 & ~(3'(1) << (n % N));
            step();
            cyc = 3'b111;
            step();
        end
        cyc = '0; stb = '0; s_ack = 1'b0;
        step();
        step();

        // Random traffic: a balanced phase, then a slow-slave phase for timeouts.
        for (int t = 0; t < 4000; t++) begin
            bit slow;
            slow = (t >= 2000);
            rstn = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, slow ? 15 : 3) == 0) cyc[i] = ~cyc[i];
                stb[i] = slow ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) != 0);
            end
            we     = 3'($urandom);
            adr    = {$urandom, $urandom, $urandom};
            dat    = {$urandom, $urandom, $urandom};
            sel    = 12'($urandom);
            s_dati = $urandom;
            s_ack  = slow ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 5) == 0);
            s_err  = slow ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 19) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
